// File: rtl/sdram_rd_arbiter_if.sv
// Requester and SDRAM-side read signals of the read arbiter.
// Latency: none, this is a plain signal bundle.
// Backpressure: requests are held high until acknowledged; SDRAM side is strobe-based.
interface sdram_rd_arbiter_if;
  logic        p0_req;
  logic [24:0] p0_addr;
  logic        p0_ack;
  logic [15:0] p0_data;
  logic        p1_req;
  logic [24:0] p1_addr;
  logic        p1_ack;
  logic [15:0] p1_data;
  logic [24:0] sdram_addr;
  logic        sdram_rd;
  logic [15:0] sdram_data;
  logic        sdram_rdy;

  // Arbiter view: accepts requests, drives the acks and the SDRAM read strobe.
  modport master (
    input  p0_req, p0_addr, p1_req, p1_addr, sdram_data, sdram_rdy,
    output p0_ack, p0_data, p1_ack, p1_data, sdram_addr, sdram_rd
  );

  // Environment view: the requesters plus the SDRAM controller.
  modport slave (
    output p0_req, p0_addr, p1_req, p1_addr, sdram_data, sdram_rdy,
    input  p0_ack, p0_data, p1_ack, p1_data, sdram_addr, sdram_rd
  );
endinterface

// File: rtl/sdram_rd_arbiter.sv
// Two-port SDRAM read arbiter with starvation guard for port 1 and a WAIT timeout.
// Latency: req in cycle N, sdram_rdy in N+3 gives ack in N+4; one IDLE cycle between transactions.
// Backpressure: requests stay pending while busy or while hold is high; nothing is dropped.
module sdram_rd_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [24:0]          base_addr,
  input  logic                 hold,
  output logic                 busy,
  output logic                 tmo,
  sdram_rd_arbiter_if.master   bus
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;          // granted port: 0 or 1
  logic          pick_p1;
  logic [CW-1:0] wcnt, wcnt_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic [24:0]   addr_r, addr_nxt;
  logic          rd_r, rd_nxt;
  logic          ack0_r, ack0_nxt, ack1_r, ack1_nxt;
  logic [15:0]   d0_r, d0_nxt, d1_r, d1_nxt;
  logic          busy_r, busy_nxt, tmo_r, tmo_nxt;

  assign bus.sdram_addr = addr_r;
  assign bus.sdram_rd   = rd_r;
  assign bus.p0_ack     = ack0_r;
  assign bus.p1_ack     = ack1_r;
  assign bus.p0_data    = d0_r;
  assign bus.p1_data    = d1_r;
  assign busy           = busy_r;
  assign tmo            = tmo_r;

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    wcnt_nxt   = wcnt;
    starve_nxt = starve;
    addr_nxt   = addr_r;
    rd_nxt     = 1'b0;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    d0_nxt     = d0_r;
    d1_nxt     = d1_r;
    tmo_nxt    = 1'b0;
    pick_p1    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.p1_req) starve_nxt = '0;
        if (!hold && (bus.p0_req || bus.p1_req)) begin
          // Port 0 wins ties until port 1 has been passed over STARVE_MAX times.
          pick_p1   = bus.p1_req && (!bus.p0_req || starve == STARVE_TOP);
          gnt_nxt   = pick_p1;
          addr_nxt  = base_addr + (pick_p1 ? bus.p1_addr : bus.p0_addr);
          rd_nxt    = 1'b1;
          state_nxt = ISSUE;
          if (pick_p1)
            starve_nxt = '0;
          else if (bus.p1_req && starve != STARVE_TOP)
            starve_nxt = starve + 1'b1;
        end
      end
      ISSUE: begin
        wcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.sdram_rdy) begin
          if (gnt) d1_nxt = bus.sdram_data;
          else     d0_nxt = bus.sdram_data;
          ack0_nxt  = !gnt;
          ack1_nxt  = gnt;
          state_nxt = DONE;
        end else if (wcnt == WAIT_LAST) begin
          // Forced completion: the requester still gets an ack, with zero data.
          if (gnt) d1_nxt = 16'h0000;
          else     d0_nxt = 16'h0000;
          ack0_nxt  = !gnt;
          ack1_nxt  = gnt;
          tmo_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      wcnt   <= '0;
      starve <= '0;
      addr_r <= '0;
      rd_r   <= 1'b0;
      ack0_r <= 1'b0;
      ack1_r <= 1'b0;
      d0_r   <= '0;
      d1_r   <= '0;
      busy_r <= 1'b0;
      tmo_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      wcnt   <= wcnt_nxt;
      starve <= starve_nxt;
      addr_r <= addr_nxt;
      rd_r   <= rd_nxt;
      ack0_r <= ack0_nxt;
      ack1_r <= ack1_nxt;
      d0_r   <= d0_nxt;
      d1_r   <= d1_nxt;
      busy_r <= busy_nxt;
      tmo_r  <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed bench for sdram_rd_arbiter: reset, latency, priority, timeout, hold, wrap, abort.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: requests are held until their ack, as a real requester would.
module tb_sdram_rd_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] base_addr;
  logic        hold;
  logic        busy;
  logic        tmo;
  int          n_chk  = 0;
  int          n_fail = 0;

  sdram_rd_arbiter_if bus();

  sdram_rd_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .base_addr (base_addr),
    .hold      (hold),
    .busy      (busy),
    .tmo       (tmo),
    .bus       (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; base_addr = '0;
    bus.p0_req = 1'b0; bus.p0_addr = '0; bus.p1_req = 1'b0; bus.p1_addr = '0;
    bus.sdram_data = '0; bus.sdram_rdy = 1'b0;
    cyc(); cyc();
    n_chk++; if (bus.sdram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b want 0", bus.sdram_rd); end
    n_chk++; if ({bus.p0_ack, bus.p1_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", {bus.p0_ack, bus.p1_ack}); end
    n_chk++; if ({busy, tmo} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_tmo: got %b want 00", {busy, tmo}); end
    n_chk++; if (bus.sdram_addr !== 25'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.sdram_addr); end
    n_chk++; if ({bus.p0_data, bus.p1_data} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {bus.p0_data, bus.p1_data}); end
    reset = 1'b0;
    cyc();
  endtask

  // Request in cycle N, rdy in N+3, ack expected in N+4.
  task automatic test_basic();
    base_addr = 25'h100000; bus.p0_addr = 25'h0042; bus.p0_req = 1'b1;
    cyc();
    n_chk++; if (bus.sdram_rd !== 1'b1) begin n_fail++; $display("FAIL basic_rd: got %b want 1", bus.sdram_rd); end
    n_chk++; if (bus.sdram_addr !== 25'h100042) begin n_fail++; $display("FAIL basic_addr: got %h want 100042", bus.sdram_addr); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    cyc();
    n_chk++; if (bus.sdram_rd !== 1'b0) begin n_fail++; $display("FAIL basic_rd_single: got %b want 0", bus.sdram_rd); end
    cyc();
    n_chk++; if (bus.p0_ack !== 1'b0) begin n_fail++; $display("FAIL basic_early_ack: got %b want 0", bus.p0_ack); end
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'hBEEF;
    cyc();
    bus.sdram_rdy = 1'b0;
    n_chk++; if (bus.p0_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b want 1", bus.p0_ack); end
    n_chk++; if (bus.p0_data !== 16'hBEEF) begin n_fail++; $display("FAIL basic_data: got %h want beef", bus.p0_data); end
    n_chk++; if ({bus.p1_ack, tmo} !== 2'b00) begin n_fail++; $display("FAIL basic_p1ack_tmo: got %b want 00", {bus.p1_ack, tmo}); end
    bus.p0_req = 1'b0;
    cyc();
    n_chk++; if ({bus.p0_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after: got %b want 00", {bus.p0_ack, busy}); end
    n_chk++; if (bus.sdram_addr !== 25'h100042) begin n_fail++; $display("FAIL basic_addr_hold: got %h want 100042", bus.sdram_addr); end
    // A stray rdy while idle must change nothing.
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'h1234;
    cyc(); cyc();
    bus.sdram_rdy = 1'b0;
    n_chk++; if (bus.p0_data !== 16'hBEEF || bus.p0_ack !== 1'b0) begin n_fail++; $display("FAIL idle_rdy: got data %h ack %b want beef 0", bus.p0_data, bus.p0_ack); end
  endtask

  task automatic test_starvation();
    logic exp_g [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic g;
    base_addr = '0; bus.p0_addr = 25'h10; bus.p1_addr = 25'h20;
    bus.p0_req = 1'b1; bus.p1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int t = 0;
      while (bus.sdram_rd !== 1'b1 && t < 20) begin cyc(); t++; end
      n_chk++; if (bus.sdram_rd !== 1'b1) begin n_fail++; $display("FAIL starve_grant_%0d: no rd within %0d cycles", i, t); end
      g = (bus.sdram_addr == 25'h20);
      n_chk++; if (g !== exp_g[i]) begin n_fail++; $display("FAIL starve_order_%0d: got port %0d want port %0d", i, g, exp_g[i]); end
      cyc();
      bus.sdram_rdy = 1'b1; bus.sdram_data = 16'hA000 + 16'(i);
      cyc();
      bus.sdram_rdy = 1'b0;
      if (i == 9) begin bus.p0_req = 1'b0; bus.p1_req = 1'b0; end
      n_chk++; if ({bus.p1_ack, bus.p0_ack} !== (exp_g[i] ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL starve_ack_%0d: got %b", i, {bus.p1_ack, bus.p0_ack}); end
    end
    cyc(); cyc();
  endtask

  task automatic test_timeout();
    base_addr = '0; bus.p0_addr = 25'h5; bus.p0_req = 1'b1;
    cyc();
    n_chk++; if (bus.sdram_rd !== 1'b1) begin n_fail++; $display("FAIL tmo_rd: got %b want 1", bus.sdram_rd); end
    cyc();
    bus.p1_addr = 25'h77; bus.p1_req = 1'b1;
    repeat (63) cyc();
    n_chk++; if ({bus.p0_ack, tmo} !== 2'b00) begin n_fail++; $display("FAIL tmo_early: got %b want 00", {bus.p0_ack, tmo}); end
    cyc();
    n_chk++; if ({bus.p0_ack, tmo} !== 2'b11) begin n_fail++; $display("FAIL tmo_fire: got %b want 11", {bus.p0_ack, tmo}); end
    n_chk++; if (bus.p0_data !== 16'h0000) begin n_fail++; $display("FAIL tmo_data: got %h want 0000", bus.p0_data); end
    bus.p0_req = 1'b0;
    cyc();
    n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse: got %b want 0", tmo); end
    cyc();
    n_chk++; if (bus.sdram_rd !== 1'b1 || bus.sdram_addr !== 25'h77) begin n_fail++; $display("FAIL tmo_next: got rd %b addr %h want 1 77", bus.sdram_rd, bus.sdram_addr); end
    cyc();
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'h7777;
    cyc();
    bus.sdram_rdy = 1'b0; bus.p1_req = 1'b0;
    n_chk++; if (bus.p1_ack !== 1'b1 || bus.p1_data !== 16'h7777 || tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_next_ack: got ack %b data %h tmo %b want 1 7777 0", bus.p1_ack, bus.p1_data, tmo); end
    cyc();
  endtask

  // rdy arriving on the last WAIT cycle beats the timeout.
  task automatic test_timeout_tie();
    bus.p0_addr = 25'h6; bus.p0_req = 1'b1;
    cyc(); cyc();
    repeat (63) cyc();
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'hCAFE;
    cyc();
    bus.sdram_rdy = 1'b0; bus.p0_req = 1'b0;
    n_chk++; if ({bus.p0_ack, tmo} !== 2'b10) begin n_fail++; $display("FAIL tie_ack_tmo: got %b want 10", {bus.p0_ack, tmo}); end
    n_chk++; if (bus.p0_data !== 16'hCAFE) begin n_fail++; $display("FAIL tie_data: got %h want cafe", bus.p0_data); end
    cyc();
  endtask

  task automatic test_hold();
    bus.p0_addr = 25'h8; bus.p0_req = 1'b1;
    cyc(); cyc();
    hold = 1'b1; bus.p1_addr = 25'h99; bus.p1_req = 1'b1;
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'h8888;
    cyc();
    bus.sdram_rdy = 1'b0; bus.p0_req = 1'b0;
    n_chk++; if (bus.p0_ack !== 1'b1 || bus.p0_data !== 16'h8888) begin n_fail++; $display("FAIL hold_ack: got %b %h want 1 8888", bus.p0_ack, bus.p0_data); end
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_chk++; if (bus.sdram_rd !== 1'b0) begin n_fail++; $display("FAIL hold_block_%0d: got rd %b want 0", i, bus.sdram_rd); end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_busy: got %b want 0", busy); end
    hold = 1'b0;
    cyc();
    n_chk++; if (bus.sdram_rd !== 1'b1 || bus.sdram_addr !== 25'h99) begin n_fail++; $display("FAIL hold_release: got rd %b addr %h want 1 99", bus.sdram_rd, bus.sdram_addr); end
    cyc();
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'h9999;
    cyc();
    bus.sdram_rdy = 1'b0; bus.p1_req = 1'b0;
    n_chk++; if (bus.p1_ack !== 1'b1 || bus.p1_data !== 16'h9999) begin n_fail++; $display("FAIL hold_p1_ack: got %b %h want 1 9999", bus.p1_ack, bus.p1_data); end
    cyc();
  endtask

  task automatic test_wrap();
    base_addr = 25'h1FFFFFF; bus.p0_addr = 25'h2; bus.p0_req = 1'b1;
    cyc();
    n_chk++; if (bus.sdram_addr !== 25'h0000001) begin n_fail++; $display("FAIL wrap_addr: got %h want 0000001", bus.sdram_addr); end
    cyc();
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'h0101;
    cyc();
    bus.sdram_rdy = 1'b0; bus.p0_req = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    base_addr = '0; bus.p0_addr = 25'h3; bus.p0_req = 1'b1;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; bus.p0_req = 1'b0;
    n_chk++; if ({busy, bus.p0_ack, bus.sdram_rd} !== 3'b000) begin n_fail++; $display("FAIL abort_state: got %b want 000", {busy, bus.p0_ack, bus.sdram_rd}); end
    bus.sdram_rdy = 1'b1; bus.sdram_data = 16'h1111;
    cyc();
    bus.sdram_rdy = 1'b0;
    n_chk++; if ({bus.p0_ack, busy} !== 2'b00 || bus.p0_data !== 16'h0) begin n_fail++; $display("FAIL abort_late_rdy: got ack/busy %b data %h want 00 0000", {bus.p0_ack, busy}, bus.p0_data); end
    cyc();
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starvation();
    test_timeout();
    test_timeout_tie();
    test_hold();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/sdram_rd_arbiter.md
SDRAM_RD_ARBITER -- requirements
Module: sdram_rd_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive port-0 grants allowed while port 1 is waiting.
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum WAIT cycles before a forced completion.
REQ-003 SHALL have port clk_sys  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port base_addr  input  25  image base offset added to every request address.
REQ-006 SHALL have port hold  input  1  blocks new grants (driven by ioctl_download).
REQ-007 SHALL have port p0_req  input  1  port 0 (LCD fetch) request, held until ack.
REQ-008 SHALL have port p0_addr  input  25  port 0 relative address, stable while p0_req is high.
REQ-009 SHALL have port p0_ack  output  1  one-cycle completion pulse for port 0.
REQ-010 SHALL have port p0_data  output  16  port 0 read data, valid when p0_ack is high.
REQ-011 SHALL have ports p1_req/p1_addr/p1_ack/p1_data  same directions and widths as port 0  auxiliary requester.
REQ-012 SHALL have port sdram_addr  output  25  absolute SDRAM address.
REQ-013 SHALL have port sdram_rd  output  1  one-cycle read strobe.
REQ-014 SHALL have port sdram_data  input  16  SDRAM read data.
REQ-015 SHALL have port sdram_rdy  input  1  data-valid strobe from the SDRAM controller.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.
REQ-017 SHALL have port tmo  output  1  one-cycle pulse on a timeout completion.

Function
REQ-018 SHALL implement states IDLE, ISSUE, WAIT and DONE, with all outputs registered.
REQ-019 IDLE: SHALL go to ISSUE on any req when hold=0, latch the grant, and latch sdram_addr = base_addr + granted addr, modulo 2^25 (carry discarded).
REQ-020 ISSUE: SHALL drive sdram_rd=1 for exactly one cycle, then go to WAIT; the WAIT cycle counter clears to 0.
REQ-021 WAIT: on sdram_rdy=1 SHALL latch sdram_data into the granted port's data register and go to DONE.
REQ-022 WAIT: when the counter reaches TIMEOUT-1 with sdram_rdy=0, SHALL load 16'h0000 as data, pulse tmo, and go to DONE.
REQ-023 If sdram_rdy and timeout expiry coincide, sdram_rdy SHALL win and tmo SHALL stay 0.
REQ-024 DONE: SHALL pulse the granted port's ack for one cycle with data valid, then return to IDLE.
REQ-025 Minimum request-to-ack latency: req high in cycle N, rdy in cycle N+3 -> ack in cycle N+4.
REQ-026 An ack-to-next-grant gap of one IDLE cycle is the minimum.
REQ-027 Priority: port 0 SHALL win ties unless starve_cnt == STARVE_MAX, in which case port 1 wins.
REQ-028 starve_cnt SHALL increment (saturating at STARVE_MAX) on each port-0 grant while p1_req=1.
REQ-029 starve_cnt SHALL clear on a port-1 grant, or in any IDLE cycle with p1_req=0.
REQ-030 hold=1 SHALL block new grants only; an in-flight transaction completes normally.
REQ-031 A request arriving while busy SHALL wait, with no loss and no duplication.
REQ-032 sdram_rdy seen in IDLE, ISSUE or DONE SHALL be ignored.
REQ-033 pX_data SHALL hold its last value until the next completion on that port.
REQ-034 sdram_addr SHALL hold its last value outside ISSUE.
REQ-035 A change of base_addr SHALL affect only grants made after the change.

Reset
REQ-036 On reset=1 at a clock edge: state=IDLE; sdram_rd, p0_ack, p1_ack, busy and tmo = 0; sdram_addr, p0_data and p1_data = 0; starve_cnt and the WAIT counter = 0.
REQ-037 Reset mid-transaction SHALL abort it with no ack, and a late sdram_rdy SHALL be ignored.

Verification
REQ-038 base=0x100000, p0_req addr=0x0042, rdy 3 cycles after rd with data 0xBEEF -> sdram_addr=0x100042, one rd pulse, p0_ack with p0_data=0xBEEF, latency per REQ-025.
REQ-039 p0 and p1 requesting continuously, STARVE_MAX=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
REQ-040 rdy never arrives, TIMEOUT=64 -> tmo and ack 64 cycles after entering WAIT, data 0x0000, then the next grant proceeds.
REQ-041 hold raised during WAIT -> current ack delivered, no further rd while hold=1, pending p1 granted the cycle after hold falls.
REQ-042 base=0x1FFFFFF, addr=0x2 -> sdram_addr=0x0000001.
REQ-043 reset asserted in WAIT, then rdy pulse -> no ack, busy=0, and the next request behaves per REQ-038.
